// File: rtl/ariane_pkg.sv
// Shared core types used by the branch-history-table maintenance logic.
// Holds the update request, the stored entry layout and the walk patterns.
package ariane_pkg;

  localparam int unsigned VLEN            = 64;
  localparam int unsigned INSTR_PER_FETCH = 2;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] counter;
  } bht_entry_t;

  localparam bht_entry_t BHT_ENTRY_CLEAR = 3'b000;
  localparam bht_entry_t BHT_ENTRY_FLUSH = 3'b010;

  typedef enum logic [1:0] {
    BHT_WALK,
    BHT_IDLE,
    BHT_RD,
    BHT_WR
  } bht_state_e;

  // Two-bit saturating predictor counter step.
  function automatic logic [1:0] bht_sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/bht_update_ctrl_fifo.sv
// Small register-file queue holding pending BHT updates {row, column, taken}.
// A push and pop together keep occupancy; a pop on an empty queue is ignored.
module bht_upd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        wptr_d = wptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push_ok && pop_ok) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/bht_update_ctrl.sv
// Maintenance port controller for the BHT: clear/flush table walks and
// queued read-modify-write counter updates from two round-robin requesters.
module bht_update_ctrl
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ROWS    = 512,
  parameter int unsigned COLS       = ariane_pkg::INSTR_PER_FETCH,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  input  bht_update_t                upd_a_i,
  output logic                       upd_a_ready_o,
  input  bht_update_t                upd_b_i,
  output logic                       upd_b_ready_o,
  output logic                       busy_o,
  output logic                       sram_req_o,
  output logic                       sram_we_o,
  output logic [$clog2(NR_ROWS)-1:0] sram_addr_o,
  output logic [COLS-1:0]            sram_be_o,
  output logic [COLS*3-1:0]          sram_wdata_o,
  input  logic [COLS*3-1:0]          sram_rdata_i
);

  localparam int unsigned ROW_W = $clog2(NR_ROWS);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned Q_W   = ROW_W + COL_W + 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  bht_state_e       state_q, state_d;
  logic [ROW_W-1:0] walk_cnt_q, walk_cnt_d;
  logic             walk_flush_q, walk_flush_d;
  logic             prio_b_q, prio_b_d;

  logic             restart;
  logic             can_grant;
  logic             grant_a, grant_b;
  logic [ROW_W-1:0] row_a, row_b;
  logic [COL_W-1:0] col_a, col_b;

  logic             fifo_push, fifo_pop, fifo_flush;
  logic [Q_W-1:0]   fifo_wdata, fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  logic [ROW_W-1:0] head_row;
  logic [COL_W-1:0] head_col;
  logic             head_taken;
  logic [1:0]       rd_ctr [COLS];
  logic [COLS-1:0]  unused_rd_valid;
  bht_entry_t       new_ent;
  bht_entry_t       walk_ent;
  logic [COLS-1:0]  col_onehot;
  logic [COLS*3-1:0] walk_row, upd_row;
  logic             unused_pc;

  logic              st_req, st_we;
  logic [ROW_W-1:0]  st_addr;
  logic [COLS-1:0]   st_be;
  logic [COLS*3-1:0] st_wdata;

  assign row_a = upd_a_i.pc[ROW_W+COL_W:COL_W+1];
  assign col_a = upd_a_i.pc[COL_W:1];
  assign row_b = upd_b_i.pc[ROW_W+COL_W:COL_W+1];
  assign col_b = upd_b_i.pc[COL_W:1];
  assign unused_pc = ^{upd_a_i.pc[VLEN-1:ROW_W+COL_W+1], upd_a_i.pc[0],
                       upd_b_i.pc[VLEN-1:ROW_W+COL_W+1], upd_b_i.pc[0]};

  // Requests are refused while walking and in the cycle a clear/flush is seen.
  assign restart   = clr_i || flush_i;
  assign can_grant = (state_q != BHT_WALK) && !restart && !fifo_full;
  assign grant_a   = can_grant && upd_a_i.valid && (!upd_b_i.valid || !prio_b_q);
  assign grant_b   = can_grant && upd_b_i.valid && (!upd_a_i.valid || prio_b_q);

  assign upd_a_ready_o = grant_a;
  assign upd_b_ready_o = grant_b;

  assign fifo_push  = (grant_a || grant_b) && !debug_mode_i;
  assign fifo_wdata = grant_a ? {row_a, col_a, upd_a_i.taken} : {row_b, col_b, upd_b_i.taken};

  assign prio_b_d = grant_a ? 1'b1 : (grant_b ? 1'b0 : prio_b_q);

  bht_upd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (Q_W)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_row   = fifo_rdata[Q_W-1 -: ROW_W];
  assign head_col   = fifo_rdata[1 +: COL_W];
  assign head_taken = fifo_rdata[0];

  assign walk_ent        = walk_flush_q ? BHT_ENTRY_FLUSH : BHT_ENTRY_CLEAR;
  assign new_ent.valid   = 1'b1;
  assign new_ent.counter = bht_sat_update(rd_ctr[head_col], head_taken);

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    assign rd_ctr[gi]             = sram_rdata_i[gi*3 +: 2];
    assign unused_rd_valid[gi]    = sram_rdata_i[gi*3 + 2];
    assign col_onehot[gi]         = (head_col == COL_W'(gi));
    assign walk_row[gi*3 +: 3]    = walk_ent;
    assign upd_row[gi*3 +: 3]     = new_ent;
  end

  always_comb begin
    state_d      = state_q;
    walk_cnt_d   = walk_cnt_q;
    walk_flush_d = walk_flush_q;
    st_req       = 1'b0;
    st_we        = 1'b0;
    st_addr      = head_row;
    st_be        = '0;
    st_wdata     = upd_row;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    if (restart) begin
      // Any access in flight is dropped; the new walk starts next cycle.
      state_d      = BHT_WALK;
      walk_cnt_d   = '0;
      walk_flush_d = !clr_i;
      fifo_flush   = 1'b1;
    end else begin
      unique case (state_q)
        BHT_WALK: begin
          st_req   = 1'b1;
          st_we    = 1'b1;
          st_addr  = walk_cnt_q;
          st_be    = '1;
          st_wdata = walk_row;
          if (walk_cnt_q == ROW_W'(NR_ROWS - 1)) begin
            state_d = BHT_IDLE;
          end else begin
            walk_cnt_d = walk_cnt_q + ROW_W'(1);
          end
        end
        BHT_IDLE: begin
          if (!fifo_empty) begin
            state_d = BHT_RD;
          end
        end
        BHT_RD: begin
          st_req  = 1'b1;
          state_d = BHT_WR;
        end
        BHT_WR: begin
          st_req   = 1'b1;
          st_we    = 1'b1;
          st_be    = col_onehot;
          fifo_pop = 1'b1;
          if ((fifo_count > CNT_W'(1)) || fifo_push) begin
            state_d = BHT_RD;
          end else begin
            state_d = BHT_IDLE;
          end
        end
        default: state_d = BHT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= BHT_WALK;
      walk_cnt_q   <= '0;
      walk_flush_q <= 1'b0;
      prio_b_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      walk_cnt_q   <= walk_cnt_d;
      walk_flush_q <= walk_flush_d;
      prio_b_q     <= prio_b_d;
    end
  end

  assign busy_o       = (state_q == BHT_WALK);
  assign sram_req_o   = st_req && !rst_i;
  assign sram_we_o    = st_we;
  assign sram_addr_o  = st_addr;
  assign sram_be_o    = st_be;
  assign sram_wdata_o = st_wdata;

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Scoreboard bench for bht_update_ctrl with an 8-row, 2-column table and
// a behavioural write-first array model on the maintenance port.
module tb_bht_update_ctrl;
  import ariane_pkg::*;

  localparam int NR = 8;

  typedef struct {
    logic [2:0] addr;
    logic [1:0] be;
    logic [5:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr, flush, dbg;
  bht_update_t upd_a, upd_b;
  logic        ready_a, ready_b, busy;
  logic        sram_req, sram_we;
  logic [2:0]  sram_addr;
  logic [1:0]  sram_be;
  logic [5:0]  sram_wdata;
  logic [5:0]  sram_rdata;

  logic [2:0]  sram_mem [NR][2];
  logic [2:0]  shadow   [NR][2];
  exp_t        exp_q [$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_req    = 0;
  logic        prev_rd  = 1'b0;
  logic [2:0]  prev_addr = '0;
  logic        prio_b;

  always #5 clk = ~clk;

  bht_update_ctrl #(
    .NR_ROWS    (NR),
    .COLS       (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clr_i         (clr),
    .flush_i       (flush),
    .debug_mode_i  (dbg),
    .upd_a_i       (upd_a),
    .upd_a_ready_o (ready_a),
    .upd_b_i       (upd_b),
    .upd_b_ready_o (ready_b),
    .busy_o        (busy),
    .sram_req_o    (sram_req),
    .sram_we_o     (sram_we),
    .sram_addr_o   (sram_addr),
    .sram_be_o     (sram_be),
    .sram_wdata_o  (sram_wdata),
    .sram_rdata_i  (sram_rdata)
  );

  initial begin
    for (int r = 0; r < NR; r++) begin
      sram_mem[r][0] = 3'b101;
      sram_mem[r][1] = 3'b101;
    end
    sram_rdata = '0;
  end

  always @(posedge clk) begin
    if (!rst && sram_req && sram_we) begin
      if (sram_be[0]) sram_mem[sram_addr][0] <= sram_wdata[2:0];
      if (sram_be[1]) sram_mem[sram_addr][1] <= sram_wdata[5:3];
    end
    if (!rst && sram_req && !sram_we) begin
      sram_rdata <= {sram_mem[sram_addr][1], sram_mem[sram_addr][0]};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [5:0] be_mask(input logic [1:0] be);
    return {{3{be[1]}}, {3{be[0]}}};
  endfunction

  always @(negedge clk) begin
    if (!rst && sram_req) begin
      n_req++;
      if (sram_we) begin
        $display("sram write row=%0d be=%b data=%b", sram_addr, sram_be, sram_wdata);
        if (exp_q.size() == 0) begin
          check("unexpected_wr", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", sram_addr, mon_e.addr);
          check("wr_be", sram_be, mon_e.be);
          check("wr_data", sram_wdata & be_mask(sram_be), mon_e.data);
        end
        if (sram_be != 2'b11) check("rd_before_wr", prev_rd && (prev_addr == sram_addr), 1);
      end
    end
    prev_rd   = !rst && sram_req && !sram_we;
    prev_addr = sram_addr;
  end

  task automatic push_walk(input logic [2:0] pat);
    exp_t e;
    for (int r = 0; r < NR; r++) begin
      e.addr = 3'(r);
      e.be   = 2'b11;
      e.data = {pat, pat};
      exp_q.push_back(e);
      shadow[r][0] = pat;
      shadow[r][1] = pat;
    end
  endtask

  task automatic expect_update(input logic [63:0] pc, input logic taken);
    exp_t e;
    int   c;
    logic [2:0] row;
    logic       col;
    logic [2:0] ent;
    row = pc[4:2];
    col = pc[1];
    c = int'(shadow[row][col][1:0]);
    if (taken) c = (c < 3) ? c + 1 : 3;
    else       c = (c > 0) ? c - 1 : 0;
    ent = {1'b1, 2'(c)};
    shadow[row][col] = ent;
    e.addr = row;
    e.be   = col ? 2'b10 : 2'b01;
    e.data = col ? {ent, 3'b000} : {3'b000, ent};
    exp_q.push_back(e);
  endtask

  task automatic req_one(input logic use_b, input logic [63:0] pc, input logic taken);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    upd_a.valid = !use_b; upd_a.pc = pc; upd_a.taken = taken;
    upd_b.valid = use_b;  upd_b.pc = pc; upd_b.taken = taken;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (use_b ? ready_b : ready_a) begin
        got = 1'b1;
        $display("grant %s pc=%0d taken=%0d dbg=%0d", use_b ? "B" : "A", pc, taken, dbg);
        if (!dbg) expect_update(pc, taken);
        prio_b = !prio_b;
        break;
      end
    end
    check("grant_timeout", got, 1);
  endtask

  task automatic idle_inputs();
    @(posedge clk); #1;
    upd_a = '0;
    upd_b = '0;
  endtask

  task automatic wait_walk(input string tag, input int exp_cycles);
    int n;
    n = 0;
    for (int i = 0; i < 4 * NR; i++) begin
      @(negedge clk); #1;
      if (busy) n++;
      else break;
    end
    check(tag, n, exp_cycles);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !busy) break;
    end
    repeat (6) @(negedge clk);
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   occ;
    int   n0;
    logic saw_full;
    logic wr_now;
    rst = 1'b1; clr = 1'b0; flush = 1'b0; dbg = 1'b0;
    upd_a = '0; upd_b = '0;
    upd_a.valid = 1'b1;
    upd_b.valid = 1'b1;
    prio_b = 1'b0;

    // Reset, then the full clear walk
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_busy", busy, 1);
    check("rst_req", sram_req, 0);
    check("rst_rdy_a", ready_a, 0);
    check("rst_rdy_b", ready_b, 0);
    push_walk(3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    upd_a = '0; upd_b = '0;
    wait_walk("clr_walk_len", NR);

    // Saturating updates on row 3 column 1
    upd_a.valid = 1'b1; upd_a.pc = 64'd14; upd_a.taken = 1'b1;
    #1;
    check("idle_ready", ready_a, 1);
    if (ready_a) begin
      expect_update(64'd14, 1'b1);
      prio_b = !prio_b;
    end
    idle_inputs();
    drain("first_update");
    for (int k = 0; k < 4; k++) begin
      req_one(1'b0, 64'd14, 1'b1);
      idle_inputs();
      drain("sat_update");
    end

    // Both requesters busy: alternation and FIFO back-pressure
    @(posedge clk); #1;
    upd_a.valid = 1'b1; upd_a.pc = 64'd20; upd_a.taken = 1'b1;
    upd_b.valid = 1'b1; upd_b.pc = 64'd20; upd_b.taken = 1'b0;
    occ = 0;
    saw_full = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #1;
      wr_now = sram_req && sram_we;
      check("rr_onehot", ready_a && ready_b, 0);
      check("fifo_space", ready_a || ready_b, occ < 4);
      if (!ready_a && !ready_b) saw_full = 1'b1;
      if (ready_a || ready_b) begin
        check("rr_order", ready_b, prio_b);
        $display("grant %s pc=20", ready_b ? "B" : "A");
        expect_update(64'd20, ready_a);
        prio_b = !prio_b;
        occ++;
      end
      if (wr_now) occ--;
    end
    check("fifo_filled", saw_full, 1);
    idle_inputs();
    drain("rr_drain");

    // Flush raised during a WR cycle
    req_one(1'b0, 64'd8, 1'b1);
    req_one(1'b0, 64'd10, 1'b0);
    req_one(1'b0, 64'd8, 1'b1);
    idle_inputs();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (sram_req && !sram_we) break;
    end
    exp_q.delete();
    push_walk(3'b010);
    @(posedge clk); #1;
    flush = 1'b1;
    upd_a.valid = 1'b1; upd_a.pc = 64'd6;
    @(negedge clk); #1;
    check("flush_rdy", ready_a, 0);
    check("flush_wr_suppressed", sram_req, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    upd_a = '0;
    wait_walk("flush_walk_len", NR);
    drain("flush_drain");

    // clr and flush together in the middle of a flush walk
    @(posedge clk); #1;
    flush = 1'b1;
    push_walk(3'b010);
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b1; flush = 1'b1;
    exp_q.delete();
    push_walk(3'b000);
    @(negedge clk); #1;
    check("restart_req", sram_req, 0);
    @(posedge clk); #1;
    clr = 1'b0; flush = 1'b0;
    wait_walk("restart_walk_len", NR);
    drain("restart_drain");

    // Debug mode: grants without SRAM traffic
    dbg = 1'b1;
    n0 = n_req;
    req_one(1'b0, 64'd30, 1'b1);
    req_one(1'b1, 64'd30, 1'b1);
    req_one(1'b0, 64'd28, 1'b0);
    idle_inputs();
    repeat (6) @(negedge clk);
    #1;
    check("dbg_no_sram", n_req - n0, 0);
    dbg = 1'b0;
    @(posedge clk); #1;
    req_one(1'b1, 64'd30, 1'b1);
    idle_inputs();
    drain("post_dbg_drain");

    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bht_update_ctrl.md
BHT_UPDATE_CTRL -- requirements
Module: bht_update_ctrl

Interface
REQ-001 Parameter NR_ROWS, default 512: rows in the BHT array; power of two, at least 2.
REQ-002 Parameter COLS, default ariane_pkg::INSTR_PER_FETCH: entries per row.
REQ-003 Parameter FIFO_DEPTH, default 4: depth of the update queue; power of two.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Ports SHALL be:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- clr_i  in  1  zero the whole table.
- flush_i  in  1  invalidate the table and set every counter to weakly-taken.
- debug_mode_i  in  1  discard updates.
- upd_a_i  in  bht_update_t  requester A (commit): valid, pc, taken.
- upd_a_ready_o  out  1  A accepted this cycle.
- upd_b_i  in  bht_update_t  requester B (replay).
- upd_b_ready_o  out  1  B accepted this cycle.
- busy_o  out  1  table walk in progress.
- sram_req_o  out  1  maintenance-port access.
- sram_we_o  out  1  write enable.
- sram_addr_o  out  clog2(NR_ROWS)  row address.
- sram_be_o  out  COLS  per-entry write enable.
- sram_wdata_o  out  COLS*3  entries; each entry is {valid, counter[1:0]}.
- sram_rdata_i  in  COLS*3  read data, one cycle after the read request.

Function
REQ-006 Addressing SHALL use column = pc[clog2(COLS):1] and row = pc[clog2(NR_ROWS)+clog2(COLS):clog2(COLS)+1].
REQ-007 The state machine SHALL have four states: WALK, IDLE, RD, WR.
REQ-008 In WALK, the block SHALL write one row per cycle, with all bits of sram_be_o set and sram_addr_o counting from 0 to NR_ROWS-1, then enter IDLE.
- The walk takes exactly NR_ROWS cycles.
- A clear walk writes all zeros.
- A flush walk writes valid=0 and counter=2'b10 in every entry.
REQ-009 busy_o SHALL be high exactly while in WALK.
REQ-010 Both ready outputs SHALL be low in WALK.
REQ-011 Outside WALK, at most one requester SHALL be granted per cycle, and only when the FIFO is not full.
REQ-012 Arbitration SHALL be round-robin.
- After reset, A has priority.
- Priority passes to the other requester after each grant.
- A lone valid requester is granted regardless of priority.
REQ-013 A granted request with debug_mode_i=1 SHALL still raise ready but SHALL NOT be enqueued.
REQ-014 From IDLE with the FIFO non-empty, the block SHALL go to RD. RD drives sram_req_o=1, sram_we_o=0 and the row of the FIFO head.
REQ-015 From RD the block SHALL go to WR. WR drives sram_req_o=1, sram_we_o=1, the same row and one-hot sram_be_o for the head's column.
- The written entry has valid=1 and the counter updated with 2-bit saturation: increment if taken, decrement if not, holding at 3 and 0.
- WR pops the FIFO.
- WR returns to RD if the FIFO is still non-empty after the pop, otherwise to IDLE.
REQ-016 Update throughput SHALL be one update per 2 cycles.
REQ-017 Back-to-back updates to the same entry SHALL read the value written by the previous WR; the array returns write-first data.
REQ-018 An enqueue and a pop in the same cycle SHALL be legal on a full FIFO, with occupancy unchanged; it SHALL also be legal on an empty FIFO, as a pass-through in the following cycle.
REQ-019 clr_i or flush_i in any state SHALL act as follows:
- Abort any RD/WR in progress.
- Empty the FIFO.
- Reset the walk counter to 0.
- Enter WALK next cycle.
REQ-020 If clr_i and flush_i are both high, clr_i SHALL win.
REQ-021 clr_i or flush_i during WALK SHALL restart the walk from row 0 with the new pattern.
REQ-022 In the cycle clr_i or flush_i is sampled, both ready outputs SHALL be low.
REQ-023 sram_req_o SHALL be low in IDLE.

Reset
REQ-024 While rst_i is high, the block SHALL hold:
- state WALK with the clear pattern and walk counter 0;
- FIFO empty;
- round-robin priority on A;
- sram_req_o=0 and both ready outputs low.
REQ-025 After rst_i falls, the block SHALL perform a full clear walk, so busy_o stays high for NR_ROWS cycles.

Structure
REQ-026 The bht_entry_t typedef ({valid, counter[1:0]}) and the walk-pattern constants SHALL be added to ariane_pkg next to bht_update_t.
REQ-027 The update queue SHALL be a separate sub-module, bht_upd_fifo: FIFO_DEPTH entries of {row, column, taken}, with push/pop/full/empty and a synchronous flush.
REQ-028 The block SHALL contain a single FSM and no other sub-modules.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset then idle with NR_ROWS=8: eight zero writes at rows 0..7 with all byte-enables, busy_o then falls and ready is available.
- A single taken update on an entry with counter 0: RD then WR, writing {1,01}; three more taken updates end at {1,11}, and a fourth stays at {1,11}.
- A and B valid every cycle: grants alternate A, B, A, B; the FIFO fills at 4 and ready drops until WR pops.
- flush_i raised during WR: the write is suppressed, the FIFO empties and a walk writes {0,10} to every row.
- clr_i and flush_i asserted together mid-walk: the walk restarts at row 0 with the zero pattern.
- Updates with debug_mode_i=1: ready is high and no SRAM access occurs.
